register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//   Parametrised multi-read-port integer register file with a write-through bypass
//   and a per-register busy scoreboard.
//   - Sits between decode (read/issue) and writeback in the pipelined core.
//   - Supplies NREAD operands per cycle and flags operands whose producer has not
//     yet written back, so the hazard unit can stall.
//   - x0 reads zero, ignores writes and is never busy.
// PARAMETERS
//   XLEN    32  data width of each register
//   NREGS   32  number of architectural registers (power of two, >=2); AW = $clog2(NREGS)
//   NREAD   2   number of read ports (1..4)
//   BYPASS  1   1: same-cycle write visible on reads (write-through); 0: reads return old value
// PORTS
//   clk          in   1           rising-edge clock
//   reset        in   1           synchronous, active-high
//   rs_addr      in   NREAD*AW    read addresses; port i at [i*AW +: AW]
//   rs_data      out  NREAD*XLEN  read data; port i at [i*XLEN +: XLEN]
//   rs_busy      out  NREAD       1 = register at rs_addr[i] has a pending producer
//   rd_addr      in   AW          writeback destination
//   write_data   in   XLEN        writeback data
//   reg_write    in   1           writeback enable
//   issue_valid  in   1           instruction with a destination issues this cycle
//   issue_rd     in   AW          destination of the issuing instruction
//   busy_vec     out  NREGS       full scoreboard, for debug/hazard unit
// BEHAVIOUR
//   - Clock and reset: one clock; reset is synchronous and active-high.
//     While reset=1 at a rising edge, all registers clear to 0 and all busy bits clear.
//     reg_write/issue_valid are ignored that cycle.
//   - Reset values: rs_data is combinational from the array, so it reads 0 after reset;
//     rs_busy=0; busy_vec=0.
//   - Write: at posedge, if reg_write && rd_addr!=0, mem[rd_addr] <= write_data. Latency 1 edge.
//   - Read: combinational, zero latency.
//     - rs_addr[i]==0 -> rs_data[i]=0, rs_busy[i]=0, regardless of bypass.
//     - BYPASS=1 and reg_write && rd_addr==rs_addr[i]!=0 -> rs_data[i]=write_data.
//     - Otherwise rs_data[i]=mem[rs_addr[i]].
//   - Scoreboard: one bit per register; bit 0 is tied 0.
//     - Set at posedge when issue_valid && issue_rd!=0.
//     - Cleared at posedge when reg_write && rd_addr!=0.
//     - Same register set and cleared in one cycle: set wins (the newer producer is outstanding).
//     - Set an already-set bit: stays 1. Clear an already-clear bit: stays 0 (no error).
//   - rs_busy[i]: busy[rs_addr[i]] && !(BYPASS && reg_write && rd_addr==rs_addr[i]).
//     A value arriving this cycle is forwarded, so it is not busy. With BYPASS=0 the
//     current busy bit is reported unchanged.
//   - Multiple read ports may address the same register; each port resolves independently.
//   - No write-port conflicts: single write port.
//   - Widths: all data is XLEN wide, with no sign handling. Out-of-range addresses
//     cannot occur because NREGS is 2^AW.
//   - Reset asserted mid-operation: pending busy bits and data are discarded at that edge.
// STRUCTURE
//   - Shared package rf_pkg:
//     - clog2-based AW helper
//     - XLEN_DEFAULT, NREGS_DEFAULT
//     - ZERO_REG = 0
//   - Sub-module rf_scoreboard (NREGS): holds the busy bit-vector, the set/clear priority
//     and the x0 tie-off; outputs busy_vec.
//   - The top level holds the storage array, per-port bypass muxes (generate loop over
//     NREAD) and rs_busy gating.
// TESTING
//   1. reset=1 for 2 edges, then read x1..x31 on all ports -> rs_data=0, rs_busy=0, busy_vec=0.
//   2. Write x1=ABCD1234 and x2=87654321 on successive edges; rs_addr={x2,x1}
//      -> rs_data={87654321,ABCD1234} the following cycle.
//   3. reg_write rd=0 data=12345678, then read x0 -> 0; issue_rd=0 -> busy_vec[0] stays 0.
//   4. BYPASS=1: reg_write rd=5 data=DEADBEEF with rs_addr[0]=5 in the same cycle
//      -> rs_data[0]=DEADBEEF, rs_busy[0]=0 before the edge.
//      BYPASS=0 build: the same stimulus returns the old mem[5].
//   5. Scoreboard:
//      - issue rd=7 -> busy_vec[7]=1 and rs_busy=1 when rs_addr=7.
//      - Next cycle, issue rd=7 with reg_write rd=7 -> bit stays 1.
//      - Then reg_write rd=7 alone -> bit clears.
//   6. Issue rd=3,4,9 over three cycles, then assert reset mid-sequence with reg_write rd=3
//      -> after the edge busy_vec=0 and mem[3]=0. Regression with NREAD=3, XLEN=64, NREGS=16.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int ZERO_REG      = 0;

  // Address width for a power-of-two register count; never less than one bit.
  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set wins on collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  localparam int AW   = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
    if (gi == ZERO_REG) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_reg
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (set_addr == AW'(gi));
      assign clr_hit = clr_en && (clr_addr == AW'(gi));
      // A new producer issuing in the writeback cycle keeps the register busy.
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional write-through bypass and busy scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic [AW-1:0]         rd_addr,
  input  logic [XLEN-1:0]       write_data,
  input  logic                  reg_write,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic [NREGS-1:0]      busy_vec
);

  logic [XLEN-1:0] mem_reg [NREGS];
  logic            wr_en;
  logic            issue_en;

  assign wr_en    = reg_write && (rd_addr != AW'(ZERO_REG));
  assign issue_en = issue_valid && (issue_rd != AW'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[rd_addr] <= write_data;
    end
  end

  rf_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (issue_en),
    .set_addr(issue_rd),
    .clr_en  (wr_en),
    .clr_addr(rd_addr),
    .busy_vec(busy_vec)
  );

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
    logic [AW-1:0]   addr;
    logic            is_zero;
    logic            fwd_hit;
    logic [XLEN-1:0] data;

    assign addr    = rs_addr[gi*AW +: AW];
    assign is_zero = (addr == AW'(ZERO_REG));
    // A value being written back this cycle is forwarded and therefore no longer busy.
    assign fwd_hit = (BYPASS != 0) && wr_en && (rd_addr == addr);

    always_comb begin
      data = mem_reg[addr];
      if (is_zero) begin
        data = '0;
      end else if (fwd_hit) begin
        data = write_data;
      end
    end

    assign rs_data[gi*XLEN +: XLEN] = data;
    assign rs_busy[gi]              = busy_vec[addr] && !is_zero && !fwd_hit;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default build (bypass, 2 ports) plus a BYPASS=0, 3-port, 64-bit, 16-register build.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default build: XLEN=32, NREGS=32, NREAD=2, BYPASS=1
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic        reg_write;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy_vec;

  // Regression build: XLEN=64, NREGS=16, NREAD=3, BYPASS=0
  logic [11:0]  b_rs_addr;
  logic [191:0] b_rs_data;
  logic [2:0]   b_rs_busy;
  logic [3:0]   b_rd_addr;
  logic [63:0]  b_write_data;
  logic         b_reg_write;
  logic         b_issue_valid;
  logic [3:0]   b_issue_rd;
  logic [15:0]  b_busy_vec;

  int total = 0;
  int bad   = 0;

  register_file_mp #(
    .XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_addr    (rs_addr),
    .rs_data    (rs_data),
    .rs_busy    (rs_busy),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .reg_write  (reg_write),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .busy_vec   (busy_vec)
  );

  register_file_mp #(
    .XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(0)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .rs_addr    (b_rs_addr),
    .rs_data    (b_rs_data),
    .rs_busy    (b_rs_busy),
    .rd_addr    (b_rd_addr),
    .write_data (b_write_data),
    .reg_write  (b_reg_write),
    .issue_valid(b_issue_valid),
    .issue_rd   (b_issue_rd),
    .busy_vec   (b_busy_vec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    rs_addr = '0; rd_addr = '0; write_data = '0; reg_write = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    b_rs_addr = '0; b_rd_addr = '0; b_write_data = '0; b_reg_write = 1'b0;
    b_issue_valid = 1'b0; b_issue_rd = '0;

    // 1: reset for two edges, everything reads zero
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_busy_vec", 64'(busy_vec), 64'h0);
    chk("reset_b_busy_vec", 64'(b_busy_vec), 64'h0);
    for (int r = 1; r < 32; r++) begin
      rs_addr = {5'(r), 5'(r)};
      #1;
      chk($sformatf("reset_data_x%0d", r), rs_data, 64'h0);
      chk($sformatf("reset_busy_x%0d", r), 64'(rs_busy), 64'h0);
    end
    $display("step reset: read x1..x31 after reset");

    // 2: two writes on successive edges, read back on both ports
    rd_addr = 5'd1; write_data = 32'hABCD1234; reg_write = 1'b1;
    tick();
    rd_addr = 5'd2; write_data = 32'h87654321;
    tick();
    reg_write = 1'b0;
    rs_addr = {5'd2, 5'd1};
    #1;
    chk("write_read_x2_x1", rs_data, 64'h87654321_ABCD1234);
    $display("step write: x1=ABCD1234 x2=87654321");

    // 3: x0 ignores writes and issues
    rd_addr = 5'd0; write_data = 32'h12345678; reg_write = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs_addr = {5'd0, 5'd0};
    #1;
    chk("x0_during_write", rs_data, 64'h0);
    tick();
    reg_write = 1'b0; issue_valid = 1'b0;
    #1;
    chk("x0_after_write", rs_data, 64'h0);
    chk("x0_busy_vec", 64'(busy_vec), 64'h0);
    $display("step x0: write and issue to x0 ignored");

    // 4: same-cycle bypass on port 0, port 1 reads stored x1
    rd_addr = 5'd5; write_data = 32'hDEADBEEF; reg_write = 1'b1;
    rs_addr = {5'd1, 5'd5};
    #1;
    chk("bypass_data", rs_data, 64'hABCD1234_DEADBEEF);
    chk("bypass_busy", 64'(rs_busy), 64'h0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("bypass_stored", rs_data, 64'hABCD1234_DEADBEEF);
    chk("clear_idle_busy_vec", 64'(busy_vec), 64'h0);
    $display("step bypass: x5=DEADBEEF forwarded");

    // 5: scoreboard set, set-wins collision, clear
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    rs_addr = {5'd7, 5'd7};
    #1;
    chk("sb_set_vec", 64'(busy_vec), 64'h80);
    chk("sb_set_rs_busy", 64'(rs_busy), 64'h3);
    issue_valid = 1'b1; issue_rd = 5'd7;
    reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'h00000077;
    #1;
    chk("sb_collide_fwd_busy", 64'(rs_busy), 64'h0);
    chk("sb_collide_fwd_data", rs_data, 64'h00000077_00000077);
    tick();
    issue_valid = 1'b0; reg_write = 1'b0;
    #1;
    chk("sb_set_wins_vec", 64'(busy_vec), 64'h80);
    chk("sb_set_wins_rs_busy", 64'(rs_busy), 64'h3);
    reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'h00000099;
    tick();
    reg_write = 1'b0;
    #1;
    chk("sb_clear_vec", 64'(busy_vec), 64'h0);
    chk("sb_clear_rs_busy", 64'(rs_busy), 64'h0);
    chk("sb_clear_data", rs_data, 64'h00000099_00000099);
    $display("step scoreboard: x7 set, collide, clear");

    // 6: issue 3,4,9 (write x9 meanwhile), then reset mid-sequence
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    reg_write = 1'b1; rd_addr = 5'd9; write_data = 32'h00009999;
    tick();
    reg_write = 1'b0;
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    rs_addr = {5'd9, 5'd3};
    #1;
    chk("multi_busy_vec", 64'(busy_vec), 64'h218);
    chk("multi_rs_busy", 64'(rs_busy), 64'h3);
    chk("multi_data", rs_data, 64'h00009999_00000000);
    reset = 1'b1;
    reg_write = 1'b1; rd_addr = 5'd3; write_data = 32'h00003333;
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    reset = 1'b0; reg_write = 1'b0; issue_valid = 1'b0;
    #1;
    chk("midreset_busy_vec", 64'(busy_vec), 64'h0);
    chk("midreset_data_x9_x3", rs_data, 64'h0);
    chk("midreset_rs_busy", 64'(rs_busy), 64'h0);
    rs_addr = {5'd2, 5'd1};
    #1;
    chk("midreset_data_x2_x1", rs_data, 64'h0);
    $display("step midreset: busy and data discarded");

    // Regression build without bypass
    b_reg_write = 1'b1; b_rd_addr = 4'd5; b_write_data = 64'h11112222_33334444;
    tick();
    b_rd_addr = 4'd15; b_write_data = 64'hFFFFFFFF_00000001;
    tick();
    b_reg_write = 1'b0;
    b_issue_valid = 1'b1; b_issue_rd = 4'd5;
    tick();
    b_issue_valid = 1'b0;
    b_rs_addr = {4'd0, 4'd5, 4'd5};
    b_reg_write = 1'b1; b_rd_addr = 4'd5; b_write_data = 64'hDEADBEEF_CAFEF00D;
    #1;
    chk("b_nobypass_p0", b_rs_data[63:0], 64'h11112222_33334444);
    chk("b_nobypass_p1", b_rs_data[127:64], 64'h11112222_33334444);
    chk("b_nobypass_p2_x0", b_rs_data[191:128], 64'h0);
    chk("b_nobypass_busy", 64'(b_rs_busy), 64'h3);
    chk("b_busy_vec_set", 64'(b_busy_vec), 64'h20);
    tick();
    b_reg_write = 1'b0;
    b_rs_addr = {4'd15, 4'd5, 4'd5};
    #1;
    chk("b_after_write_p1", b_rs_data[127:64], 64'hDEADBEEF_CAFEF00D);
    chk("b_top_reg_p2", b_rs_data[191:128], 64'hFFFFFFFF_00000001);
    chk("b_after_write_busy", 64'(b_rs_busy), 64'h0);
    chk("b_busy_vec_clear", 64'(b_busy_vec), 64'h0);
    $display("step regression: BYPASS=0 NREAD=3 XLEN=64 NREGS=16");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
